// File: rtl/net_to_tran_if.sv
// ----------------------------------------------------------------------------
// net_to_tran_if : network-receive / transport-read bundle for net_to_tran
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface net_to_tran_if #(
  parameter int CW = 7
);
  logic          receiving;
  logic [7:0]    data;
  logic          filterEn;
  logic [7:0]    expectPhone;
  logic          fifoRd;
  logic [7:0]    fifoOut;
  logic          fifoEmpty;
  logic [CW-1:0] fifoCount;
  logic [7:0]    phoneNum;
  logic [7:0]    pktType;
  logic          pktDone;
  logic          pktDropped;
  logic          pktTrunc;
  logic          busy;

  modport master (
    output receiving, data, filterEn, expectPhone, fifoRd,
    input  fifoOut, fifoEmpty, fifoCount, phoneNum, pktType,
           pktDone, pktDropped, pktTrunc, busy
  );

  modport slave (
    input  receiving, data, filterEn, expectPhone, fifoRd,
    output fifoOut, fifoEmpty, fifoCount, phoneNum, pktType,
           pktDone, pktDropped, pktTrunc, busy
  );
endinterface

`default_nettype wire

// File: rtl/net_to_tran.sv
// ----------------------------------------------------------------------------
// net_to_tran : strips the 2-byte header from byte-serial packets and commits
//               whole payloads into a FIFO for the transport layer.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module net_to_tran #(
  parameter int PACKET_SIZE = 16,
  parameter int DEPTH       = 64,
  parameter int CW          = 7
) (
  input  wire logic   clk,
  input  wire logic   reset,
  net_to_tran_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(PACKET_SIZE);

  localparam logic [IW-1:0] c_last_idx = IW'(PACKET_SIZE - 1);
  localparam logic [CW:0]   c_depth    = (CW+1)'(DEPTH);
  localparam logic [CW:0]   c_pay      = (CW+1)'(PACKET_SIZE - 2);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PHONE   = 2'd1;
  localparam logic [1:0] S_PAYLOAD = 2'd2;
  localparam logic [1:0] S_DISCARD = 2'd3;

  logic [1:0]    r_state;
  logic [1:0]    w_next_state;
  logic [IW-1:0] r_idx;
  logic [CW-1:0] r_wr_tent;
  logic [CW-1:0] r_wr_commit;
  logic [CW-1:0] r_rd_ptr;
  logic [7:0]    r_type_sh;
  logic [7:0]    r_phone_sh;
  logic [7:0]    r_fifo_out;
  logic [7:0]    r_phone;
  logic [7:0]    r_type;
  logic          r_done;
  logic          r_drop;
  logic          r_trunc;
  logic [7:0]    r_mem [DEPTH];

  logic [CW-1:0] w_count;
  logic          w_empty;
  logic [CW:0]   w_free;
  logic          w_reject;
  logic          w_last;
  logic          w_rd_ok;
  logic          w_latch_type;
  logic          w_latch_phone;
  logic          w_wr_en;
  logic          w_commit;
  logic          w_rollback;
  logic          w_drop;
  logic          w_trunc;

  // Only the committed region is visible; tentative bytes sit above r_wr_commit.
  assign w_count  = r_wr_commit - r_rd_ptr;
  assign w_empty  = (w_count == '0);
  assign w_free   = c_depth - {1'b0, w_count};
  assign w_reject = (bus.filterEn && (bus.data != bus.expectPhone)) || (w_free < c_pay);
  assign w_last   = (r_idx == c_last_idx);
  assign w_rd_ok  = bus.fifoRd && !w_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (bus.receiving) w_next_state = S_PHONE;
      S_PHONE: begin
        if (!bus.receiving)  w_next_state = S_IDLE;
        else if (w_reject)   w_next_state = S_DISCARD;
        else                 w_next_state = S_PAYLOAD;
      end
      S_PAYLOAD,
      S_DISCARD: if (!bus.receiving || w_last) w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_latch_type  = 1'b0;
    w_latch_phone = 1'b0;
    w_wr_en       = 1'b0;
    w_commit      = 1'b0;
    w_rollback    = 1'b0;
    w_drop        = 1'b0;
    w_trunc       = 1'b0;
    case (r_state)
      S_IDLE:  w_latch_type = bus.receiving;
      S_PHONE: begin
        w_latch_phone = bus.receiving;
        w_trunc       = !bus.receiving;
      end
      S_PAYLOAD: begin
        if (bus.receiving) begin
          w_wr_en  = 1'b1;
          w_commit = w_last;
        end else begin
          w_rollback = 1'b1;
          w_trunc    = 1'b1;
        end
      end
      S_DISCARD: w_drop = !bus.receiving || w_last;
      default: ;
    endcase
  end

  // Storage carries no reset: pointer reset alone empties the FIFO.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_tent[AW-1:0]] <= bus.data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx       <= '0;
      r_wr_tent   <= '0;
      r_wr_commit <= '0;
      r_rd_ptr    <= '0;
      r_type_sh   <= '0;
      r_phone_sh  <= '0;
      r_fifo_out  <= '0;
      r_phone     <= '0;
      r_type      <= '0;
      r_done      <= 1'b0;
      r_drop      <= 1'b0;
      r_trunc     <= 1'b0;
    end else begin
      if (w_latch_type)        r_idx <= IW'(1);
      else if (bus.receiving)  r_idx <= r_idx + IW'(1);

      if (w_latch_type)  r_type_sh  <= bus.data;
      if (w_latch_phone) r_phone_sh <= bus.data;

      if (w_rollback)   r_wr_tent <= r_wr_commit;
      else if (w_wr_en) r_wr_tent <= r_wr_tent + CW'(1);

      if (w_commit) begin
        r_wr_commit <= r_wr_tent + CW'(1);
        r_phone     <= r_phone_sh;
        r_type      <= r_type_sh;
      end

      if (w_rd_ok) begin
        r_fifo_out <= r_mem[r_rd_ptr[AW-1:0]];
        r_rd_ptr   <= r_rd_ptr + CW'(1);
      end

      r_done  <= w_commit;
      r_drop  <= w_drop;
      r_trunc <= w_trunc;
    end
  end

  assign bus.fifoOut    = r_fifo_out;
  assign bus.fifoEmpty  = w_empty;
  assign bus.fifoCount  = w_count;
  assign bus.phoneNum   = r_phone;
  assign bus.pktType    = r_type;
  assign bus.pktDone    = r_done;
  assign bus.pktDropped = r_drop;
  assign bus.pktTrunc   = r_trunc;
  assign bus.busy       = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_net_to_tran.sv
// ----------------------------------------------------------------------------
// tb_net_to_tran : directed packet table plus hand sequences for net_to_tran
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_net_to_tran;

  localparam int PACKET_SIZE = 16;
  localparam int DEPTH       = 64;
  localparam int CW          = 7;
  localparam int P           = PACKET_SIZE - 2;

  typedef struct {
    logic [7:0] typ;
    logic [7:0] phone;
    logic [7:0] base;
    int         nbytes;
    logic       filt;
    logic [7:0] expect_ph;
    int         reads_before;
    int         outcome;      // 0 done, 1 dropped, 2 truncated
    int         exp_count;
    logic [7:0] exp_phone;
    logic [7:0] exp_type;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [7:0] q[$];
  vec_t tbl[13];
  vec_t hv;

  net_to_tran_if #(.CW(CW)) bus();

  net_to_tran #(.PACKET_SIZE(PACKET_SIZE), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic read_n(input int n);
    int e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.fifoRd = 1'b1;
      @(negedge clk);
      bus.fifoRd = 1'b0;
      e = (q.size() > 0) ? int'(q.pop_front()) : -1;
      chk("rd_data", int'(bus.fifoOut), e);
    end
  endtask

  task automatic send_pkt(input vec_t v);
    int nd = 0;
    int ndr = 0;
    int nt = 0;
    read_n(v.reads_before);
    bus.filterEn    = v.filt;
    bus.expectPhone = v.expect_ph;
    for (int k = 0; k < v.nbytes; k++) begin
      @(negedge clk);
      bus.receiving = 1'b1;
      bus.data = (k == 0) ? v.typ : (k == 1) ? v.phone : 8'(int'(v.base) + k - 2);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      nd  += int'(bus.pktDone);
      ndr += int'(bus.pktDropped);
      nt  += int'(bus.pktTrunc);
      if (c == 0) bus.receiving = 1'b0;
    end
    if (v.outcome == 0)
      for (int i = 0; i < P; i++) q.push_back(8'(int'(v.base) + i));
    chk("pkt_done_cnt",  nd,  (v.outcome == 0) ? 1 : 0);
    chk("pkt_drop_cnt",  ndr, (v.outcome == 1) ? 1 : 0);
    chk("pkt_trunc_cnt", nt,  (v.outcome == 2) ? 1 : 0);
    chk("fifo_count", int'(bus.fifoCount), v.exp_count);
    chk("fifo_empty", int'(bus.fifoEmpty), (v.exp_count == 0) ? 1 : 0);
    chk("phone_num",  int'(bus.phoneNum),  int'(v.exp_phone));
    chk("pkt_type",   int'(bus.pktType),   int'(v.exp_type));
    chk("busy_idle",  int'(bus.busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //             typ    ph     base  n   f     exp    rd  out cnt ph     typ
    tbl[0]  = '{8'h01, 8'h2A, 8'h10, 16, 1'b0, 8'h2A, 0,  0, 14, 8'h2A, 8'h01};
    tbl[1]  = '{8'h02, 8'h33, 8'h40, 16, 1'b1, 8'h2A, 14, 1, 0,  8'h2A, 8'h01};
    tbl[2]  = '{8'h03, 8'h2A, 8'h50, 16, 1'b1, 8'h2A, 0,  0, 14, 8'h2A, 8'h03};
    tbl[3]  = '{8'h04, 8'h2B, 8'h60, 9,  1'b0, 8'h2A, 0,  2, 14, 8'h2A, 8'h03};
    tbl[4]  = '{8'h05, 8'h2C, 8'h70, 16, 1'b0, 8'h2A, 14, 0, 14, 8'h2C, 8'h05};
    tbl[5]  = '{8'h06, 8'h2D, 8'h80, 16, 1'b0, 8'h2A, 0,  0, 28, 8'h2D, 8'h06};
    tbl[6]  = '{8'h07, 8'h2E, 8'h90, 16, 1'b0, 8'h2A, 0,  0, 42, 8'h2E, 8'h07};
    tbl[7]  = '{8'h08, 8'h2F, 8'hA0, 16, 1'b0, 8'h2A, 0,  0, 56, 8'h2F, 8'h08};
    tbl[8]  = '{8'h09, 8'h30, 8'hB0, 16, 1'b0, 8'h2A, 0,  1, 56, 8'h2F, 8'h08};
    tbl[9]  = '{8'h0A, 8'h31, 8'hC0, 16, 1'b0, 8'h2A, 6,  0, 64, 8'h31, 8'h0A};
    tbl[10] = '{8'h0B, 8'h32, 8'hD0, 16, 1'b1, 8'h2A, 64, 1, 0,  8'h31, 8'h0A};
    tbl[11] = '{8'h0C, 8'h99, 8'hE0, 5,  1'b1, 8'h2A, 0,  1, 0,  8'h31, 8'h0A};
    tbl[12] = '{8'h0D, 8'h2A, 8'h20, 16, 1'b0, 8'h2A, 0,  0, 14, 8'h2A, 8'h0D};

    bus.receiving   = 1'b0;
    bus.data        = 8'h00;
    bus.filterEn    = 1'b0;
    bus.expectPhone = 8'h00;
    bus.fifoRd      = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_empty", int'(bus.fifoEmpty), 1);
    chk("rst_count", int'(bus.fifoCount), 0);
    chk("rst_out",   int'(bus.fifoOut), 0);
    chk("rst_phone", int'(bus.phoneNum), 0);
    chk("rst_type",  int'(bus.pktType), 0);
    chk("rst_busy",  int'(bus.busy), 0);

    for (int i = 0; i < 13; i++) send_pkt(tbl[i]);

    // Continuous reads during a receive; the 13th read lands on the commit edge.
    bus.filterEn = 1'b0;
    for (int k = 0; k <= PACKET_SIZE; k++) begin
      @(negedge clk);
      if (k >= 4) chk("stream_rd", int'(bus.fifoOut), (q.size() > 0) ? int'(q.pop_front()) : -1);
      if (k < PACKET_SIZE) begin
        chk("stream_cnt", int'(bus.fifoCount), 14 - ((k > 3) ? k - 3 : 0));
        bus.receiving = 1'b1;
        bus.data   = (k == 0) ? 8'h0E : (k == 1) ? 8'h2A : 8'(8'h30 + k - 2);
        bus.fifoRd = (k >= 3);
      end else begin
        chk("commit_rd_cnt", int'(bus.fifoCount), 15);
        chk("commit_rd_done", int'(bus.pktDone), 1);
        for (int i = 0; i < P; i++) q.push_back(8'(8'h30 + i));
        bus.receiving = 1'b0;
        bus.fifoRd    = 1'b0;
      end
    end
    @(negedge clk);
    chk("done_one_cycle", int'(bus.pktDone), 0);
    read_n(15);
    @(negedge clk);
    bus.fifoRd = 1'b1;
    @(negedge clk);
    bus.fifoRd = 1'b0;
    chk("empty_rd_hold", int'(bus.fifoOut), 8'h3D);
    chk("empty_rd_cnt",  int'(bus.fifoCount), 0);

    // Reset in the middle of a packet with committed data present.
    hv = '{8'h0F, 8'h2A, 8'h40, 16, 1'b0, 8'h2A, 0, 0, 14, 8'h2A, 8'h0F};
    send_pkt(hv);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      bus.receiving = 1'b1;
      bus.data = (k == 0) ? 8'h11 : (k == 1) ? 8'h2A : 8'(8'h90 + k - 2);
      if (k == 5) reset = 1'b1;
    end
    #1;
    chk("mid_rst_count", int'(bus.fifoCount), 0);
    chk("mid_rst_empty", int'(bus.fifoEmpty), 1);
    chk("mid_rst_out",   int'(bus.fifoOut), 0);
    chk("mid_rst_phone", int'(bus.phoneNum), 0);
    chk("mid_rst_type",  int'(bus.pktType), 0);
    chk("mid_rst_busy",  int'(bus.busy), 0);
    @(negedge clk);
    reset = 1'b0;
    bus.receiving = 1'b0;
    q.delete();
    hv = '{8'h12, 8'h2A, 8'h60, 16, 1'b0, 8'h2A, 0, 0, 14, 8'h2A, 8'h12};
    send_pkt(hv);
    read_n(14);
    @(negedge clk);
    chk("final_empty", int'(bus.fifoEmpty), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
